// File: rtl/shift_add_mult.sv
// Sequential unsigned multiplier: one ripple-carry adder reused over N
// shift-and-add iterations, with an IDLE/RUN/DONE handshake controller.

// Plain ripple-carry adder: N full-adder cells, carry-in tied low.
module rc_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] s,
    output logic         co
);
    logic [N:0] c;

    assign c[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_fa
            assign s[i]   = a[i] ^ b[i] ^ c[i];
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign co = c[N];
endmodule

module shift_add_mult #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);
    // One extra bit keeps the counter from ever wrapping, even at N = 2^k.
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [N-1:0]     m_q;
    logic [N-1:0]     hi_q;
    logic [N-1:0]     lo_q;
    logic [CW-1:0]    cnt_q;
    logic [2*N-1:0]   product_q;

    logic [N-1:0]     add_s;
    logic             add_co;
    logic [N-1:0]     step_s;
    logic             step_c;
    logic [N-1:0]     hi_d;
    logic [N-1:0]     lo_d;
    logic             last_step;

    // The single datapath adder: HI + M.
    rc_adder #(.N(N)) u_add (
        .a  (hi_q),
        .b  (m_q),
        .s  (add_s),
        .co (add_co)
    );

    // One iteration: conditionally add M into HI, then shift {C,S,LO} right.
    // The adder carry lands in HI[N-1], so no product bit is lost.
    always_comb begin
        step_c = 1'b0;
        step_s = hi_q;
        if (lo_q[0]) begin
            step_c = add_co;
            step_s = add_s;
        end
        hi_d      = {step_c, step_s[N-1:1]};
        lo_d      = {step_s[0], lo_q[N-1:1]};
        last_step = (cnt_q == CW'(N - 1));
    end

    // Controller and datapath registers; reset overrides start and any run.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        m_q     <= a;
                        hi_q    <= '0;
                        lo_q    <= b;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_step) begin
                        product_q <= {hi_d, lo_d};
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Handshake flags are pure decodes of the state register.
    assign ready   = (state_q == IDLE);
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;
endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 Parameter N, default 32, operand width in bits; legal range 2..64.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 start  input  1  request to begin a multiply; honoured only when ready=1.
REQ-005 a  input  N  unsigned multiplicand; sampled on the accepting edge only.
REQ-006 b  input  N  unsigned multiplier; sampled on the accepting edge only.
REQ-007 ready  output  1  high in IDLE; start accepted only then.
REQ-008 busy  output  1  high while iterating (RUN).
REQ-009 done  output  1  one-cycle pulse; product valid from this cycle.
REQ-010 product  output  2N  unsigned result a*b; held until the next result is written.

Function
REQ-011 The block SHALL instantiate exactly one rc_adder with parameter N as its only adder; no other arithmetic operators on datapath words.
REQ-012 The FSM SHALL have states IDLE, RUN, DONE.
- IDLE -> RUN on start=1.
- RUN -> DONE after the N-th iteration.
- DONE -> IDLE unconditionally.
REQ-013 Accepting edge (IDLE, start=1) SHALL latch M=a, set accumulator {HI,LO} = {N'b0, b}, and clear iteration counter.
REQ-014 Each RUN edge SHALL perform one step.
- If LO[0]=1: {C,S} = HI + M from the rc_adder; else {C,S} = {0,HI}.
- New {HI,LO} = {C,S,LO} >> 1.
- Counter += 1.
REQ-015 Counter SHALL be clog2(N)+1 bits and SHALL NOT wrap during an operation; RUN exits when counter reaches N-1 on a step edge.
REQ-016 Edge leaving RUN SHALL write product = final {HI,LO}; product SHALL NOT change at any other time except reset.
REQ-017 Latency: accept at edge E0; done=1 in the cycle after edge EN; ready=1 again after edge EN+1; minimum start-to-start spacing N+2 cycles.
REQ-018 start while busy=1 or done=1 SHALL be ignored with no effect on state, operands, or product.
REQ-019 a and b changes after the accepting edge SHALL NOT affect the result.
REQ-020 ready, busy, done SHALL be decoded from state only: ready=IDLE, busy=RUN, done=DONE; mutually exclusive, exactly one high at all times.
REQ-021 Result SHALL be exact for all operands including 0 and 2^N-1; the adder carry-out SHALL be shifted into HI[N-1], never dropped.

Reset
REQ-022 reset=1 SHALL, on the next rising edge, force state IDLE, clear M, HI, LO, and counter, and set product=0.
REQ-023 Resulting outputs after reset: ready=1, busy=0, done=0.
REQ-024 reset SHALL take priority over start and over any in-progress iteration; an aborted operation SHALL produce no done pulse and no product update.
REQ-025 start asserted in the same cycle as reset SHALL be ignored.

Verification (N=32)
REQ-026 Basic case: reset, then a=3, b=5, start for 1 cycle.
- busy=1 for 32 cycles.
- done pulses exactly once, 33 cycles after the accept edge.
- product=0x0000_0000_0000_000F.
REQ-027 Corner values (each on its own run):
- a=b=0xFFFF_FFFF -> product=0xFFFF_FFFE_0000_0001.
- a=0, b=0xDEAD_BEEF -> product=0.
- a=0x8000_0000, b=2 -> product=0x0000_0001_0000_0000.
REQ-028 Ignored inputs: during run a=7, b=6, pulse start and change a/b mid-RUN.
- Product = 42.
- Exactly one done pulse.
- Prior product held unchanged until done.
REQ-029 Reset mid-operation: assert reset at iteration 10 of a 0x1234*0x5678 run.
- Next cycle: ready=1, product=0, no done pulse.
- A new 2*2 run then yields 4.
REQ-030 Back-to-back: hold start=1 continuously with a=9, b=9.
- Accepts occur every 34 cycles.
- Each done cycle shows product=81.
- ready/busy/done stay one-hot throughout.
